// File: rtl/adder_accum_sched_if.sv
// Bundle of config, operand stream, adder control and result stream
// signals for the accumulation sequencer.
interface adder_accum_sched_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 cfg_start;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic                 cfg_8bit;

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;

  logic                 add_enable;
  logic                 add_choose_8bit;
  logic [IN_WIDTH-1:0]  add_a;
  logic [ACC_WIDTH-1:0] add_b;
  logic [ACC_WIDTH-1:0] add_out;

  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;

  logic                 busy;

  modport slave (
    input  cfg_start,
    input  cfg_count,
    input  cfg_8bit,
    input  in_valid,
    output in_ready,
    input  in_data,
    output add_enable,
    output add_choose_8bit,
    output add_a,
    output add_b,
    input  add_out,
    output out_valid,
    input  out_ready,
    output out_data,
    output busy
  );

  modport master (
    output cfg_start,
    output cfg_count,
    output cfg_8bit,
    output in_valid,
    input  in_ready,
    output in_data,
    input  add_enable,
    input  add_choose_8bit,
    input  add_a,
    input  add_b,
    output add_out,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  busy
  );
endinterface

// File: rtl/adder_accum_sched.sv
// Burst sequencer driving an external registered signed adder,
// full-width or packed dual-lane, with a valid/ready result port.
module adder_accum_sched #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  adder_accum_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0] rem_d;
  logic                 first_q;
  logic                 first_d;
  logic                 mode_q;
  logic                 mode_d;
  logic                 valid_q;
  logic                 valid_d;
  logic [ACC_WIDTH-1:0] data_q;
  logic [ACC_WIDTH-1:0] data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    first_d        = first_q;
    mode_d         = mode_q;
    valid_d        = valid_q;
    data_d         = data_q;
    bus.in_ready   = 1'b0;
    bus.add_enable = 1'b0;
    bus.add_a      = '0;
    bus.add_b      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          rem_d   = bus.cfg_count;
          mode_d  = bus.cfg_8bit;
          first_d = 1'b1;
          if (bus.cfg_count == '0) begin
            data_d  = '0;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        bus.in_ready = 1'b1;
        // Feedback is last cycle's sum; the adder holds it across stalls
        bus.add_b = first_q ? '0 : bus.add_out;
        if (bus.in_valid) begin
          bus.add_enable = 1'b1;
          bus.add_a      = bus.in_data;
          rem_d          = rem_q - 1'b1;
          first_d        = 1'b0;
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        data_d  = bus.add_out;
        valid_d = 1'b1;
        state_d = HOLD;
      end

      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.add_choose_8bit = mode_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_data        = data_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_adder_accum_sched.sv
// Directed plus randomized bench for adder_accum_sched with a
// behavioural adder and an arithmetic reference sum.
module tb_adder_accum_sched;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [15:0] ops[$];
  logic [31:0] res;
  logic [31:0] adder_q;

  adder_accum_sched_if #(
    .IN_WIDTH (16),
    .ACC_WIDTH(32),
    .CNT_WIDTH(8)
  ) bus ();

  adder_accum_sched #(
    .IN_WIDTH (16),
    .ACC_WIDTH(32),
    .CNT_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External registered adder; starts with junk to expose residue
  initial adder_q = 32'h1357_9BDF;
  always @(posedge clk) begin
    if (bus.add_enable) begin
      if (bus.add_choose_8bit) begin
        adder_q[31:16] <= bus.add_b[31:16]
          + {{8{bus.add_a[15]}}, bus.add_a[15:8]};
        adder_q[15:0] <= bus.add_b[15:0]
          + {{8{bus.add_a[7]}}, bus.add_a[7:0]};
      end else begin
        adder_q <= bus.add_b + {{16{bus.add_a[15]}}, bus.add_a};
      end
    end
  end
  assign bus.add_out = adder_q;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum(input bit m8);
    int s;
    int hi;
    int lo;
    logic [15:0] v;
    s  = 0;
    hi = 0;
    lo = 0;
    foreach (ops[i]) begin
      v  = ops[i];
      s  = s + int'($signed(v));
      hi = hi + int'($signed(v[15:8]));
      lo = lo + int'($signed(v[7:0]));
    end
    if (m8) return {hi[15:0], lo[15:0]};
    return s;
  endfunction

  // gap < 0 picks a random 0..2 stall before each operand
  task automatic burst(input int n, input bit m8,
                       input int gap, input int hold,
                       output logic [31:0] r);
    int g;
    logic [31:0] exp;
    exp = (n == 0) ? 32'h0 : ref_sum(m8);
    bus.cfg_start = 1'b1;
    bus.cfg_count = 8'(n);
    bus.cfg_8bit  = m8;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cfg_count = 8'($urandom);
    bus.cfg_8bit  = ~m8;
    if (n == 0) begin
      check("zero_valid", 32'(bus.out_valid), 32'h1);
      check("zero_en", 32'(bus.add_enable), 32'h0);
      check("zero_busy", 32'(bus.busy), 32'h1);
    end else begin
      check("start_ready", 32'(bus.in_ready), 32'h1);
      check("start_mode", 32'(bus.add_choose_8bit), 32'(m8));
      for (int i = 0; i < n; i++) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int k = 0; k < g; k++) begin
          bus.in_valid = 1'b0;
          #1;
          check("stall_en", 32'(bus.add_enable), 32'h0);
          @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = ops[i];
        #1;
        check("acc_en", 32'(bus.add_enable), 32'h1);
        check("acc_a", 32'(bus.add_a), 32'(ops[i]));
        if (i == 0) check("first_b", bus.add_b, 32'h0);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 16'(-1);
      #1;
      check("drain_ready", 32'(bus.in_ready), 32'h0);
      check("drain_en", 32'(bus.add_enable), 32'h0);
      check("drain_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'h1);
    end
    r = bus.out_data;
    check("sum", r, exp);
    for (int k = 0; k < hold; k++) begin
      bus.cfg_start = (k == hold / 2);
      bus.cfg_count = 8'd3;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      check("bp_valid", 32'(bus.out_valid), 32'h1);
      check("bp_data", bus.out_data, r);
    end
    bus.out_ready = 1'b1;
    bus.cfg_start = (hold > 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.cfg_start = 1'b0;
    check("done_busy", 32'(bus.busy), 32'h0);
    check("done_valid", 32'(bus.out_valid), 32'h0);
    check("idle_en", 32'(bus.add_enable), 32'h0);
    check("idle_b", bus.add_b, 32'h0);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_count = '0;
    bus.cfg_8bit  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'h0);
    check("rst_en", 32'(bus.add_enable), 32'h0);
    check("rst_mode", 32'(bus.add_choose_8bit), 32'h0);
    check("rst_a", 32'(bus.add_a), 32'h0);
    check("rst_b", bus.add_b, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Full-width burst
    ops = {16'd5, 16'hFFFD, 16'd100, 16'hFF38};
    burst(4, 1'b0, 0, 0, res);
    check("t1_const", res, 32'hFFFF_FF9E);
    @(negedge clk);

    // Packed dual-lane burst
    ops = {16'hFF02, 16'h03FC, 16'h7F7F};
    burst(3, 1'b1, 0, 0, res);
    check("t2_const", res, 32'h0081_007D);
    @(negedge clk);

    // Stalls between operands
    ops = {16'd1, 16'd2, 16'd3};
    burst(3, 1'b0, 2, 0, res);
    check("t3_const", res, 32'd6);
    @(negedge clk);

    // Zero count
    ops = {};
    burst(0, 1'b0, 0, 0, res);
    @(negedge clk);

    // Back-pressure with ignored start in HOLD
    ops = {16'h7FFF, 16'h7FFF, 16'h8000};
    burst(3, 1'b0, 0, 5, res);
    check("t5_const", res, 32'h0000_7FFE);
    @(negedge clk);
    check("t5_idle", 32'(bus.busy), 32'h0);

    // Reset mid-burst
    bus.cfg_start = 1'b1;
    bus.cfg_count = 8'd4;
    bus.cfg_8bit  = 1'b0;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1111 * 16'(i + 3);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_ready", 32'(bus.in_ready), 32'h0);
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ops = {16'd7, 16'd8};
    burst(2, 1'b0, 0, 0, res);
    check("t6_const", res, 32'd15);
    @(negedge clk);

    // Randomized bursts against the reference sum
    for (int t = 0; t < 12; t++) begin
      int n;
      bit m8;
      n  = int'($urandom_range(1, 10));
      m8 = 1'($urandom);
      ops = {};
      for (int i = 0; i < n; i++) ops.push_back(16'($urandom));
      burst(n, m8, -1, int'($urandom_range(0, 3)), res);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
